mac_operand_feeder: RTL

Upstream operand sequencer for the 12-bit signed multiply-accumulate stage. Accepts a matrix W (M×N) and a vector x (N) over a valid/ready input stream, buffers them, then streams the M×N operand pairs (W[r][k], x[k]) to the MAC at one pair per cycle, row-major. Row-boundary flags let the downstream stage start a fresh accumulation per row, so the MAC produces one dot product y[r] per row.

---
 rtl/mac_pkg.sv | 22 ++
 rtl/feeder_regfile.sv | 35 +++
 rtl/mac_operand_feeder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared types and widths for the 12-bit signed MAC datapath
//                and its operand feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam int DATA_W = 12;
    localparam int ACC_W  = 24;

    typedef logic signed [DATA_W-1:0] operand_t;

    typedef enum logic [1:0] {
        LOAD_W  = 2'd0,
        LOAD_X  = 2'd1,
        COMPUTE = 2'd2
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/feeder_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : feeder_regfile
//  Description : DEPTH x WIDTH register file, one synchronous write port and
//                one combinational read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module feeder_regfile
    import mac_pkg::*;
#(
    parameter int DEPTH  = 9,
    parameter int WIDTH  = DATA_W,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write one word per enabled cycle; storage holds its value across reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/mac_operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : mac_operand_feeder
//  Description : Buffers an MxN matrix W and an N-vector x from a valid/ready
//                stream, then issues the MxN operand pairs (W[r][k], x[k])
//                row-major, one per cycle, with row first/last flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_operand_feeder
    import mac_pkg::*;
#(
    parameter int M      = 3,
    parameter int N      = 3,
    parameter int W_DATA = DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W_DATA-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [W_DATA-1:0] a_out,
    output logic [W_DATA-1:0] b_out,
    output logic              valid_out,
    output logic              first_out,
    output logic              last_out
);

    localparam int c_WA_W = (M * N > 1) ? $clog2(M * N) : 1;
    localparam int c_R_W  = (M > 1) ? $clog2(M) : 1;
    localparam int c_K_W  = (N > 1) ? $clog2(N) : 1;

    localparam logic [c_WA_W-1:0] c_LI_W_LAST = c_WA_W'(M * N - 1);
    localparam logic [c_WA_W-1:0] c_LI_X_LAST = c_WA_W'(N - 1);
    localparam logic [c_R_W-1:0]  c_ROW_LAST  = c_R_W'(M - 1);
    localparam logic [c_K_W-1:0]  c_COL_LAST  = c_K_W'(N - 1);

    feeder_state_t     r_state,  w_state_nxt;
    logic [c_WA_W-1:0] r_li,     w_li_nxt;
    logic [c_R_W-1:0]  r_row,    w_row_nxt;
    logic [c_K_W-1:0]  r_col,    w_col_nxt;
    logic [W_DATA-1:0] r_a,      w_a_nxt;
    logic [W_DATA-1:0] r_b,      w_b_nxt;
    logic              r_valid,  w_valid_nxt;
    logic              r_first,  w_first_nxt;
    logic              r_last,   w_last_nxt;

    logic              w_xfer;
    logic              w_w_we;
    logic              w_x_we;
    logic [c_WA_W-1:0] w_w_raddr;
    logic [W_DATA-1:0] w_w_rdata;
    logic [W_DATA-1:0] w_x_rdata;

    // Ready depends only on state (forced low while reset is held).
    assign s_ready   = !reset && (r_state != COMPUTE);
    assign w_xfer    = s_valid && s_ready;
    assign w_w_we    = w_xfer && (r_state == LOAD_W);
    assign w_x_we    = w_xfer && (r_state == LOAD_X);
    assign w_w_raddr = c_WA_W'(32'(r_row) * N + 32'(r_col));

    feeder_regfile #(
        .DEPTH (M * N),
        .WIDTH (W_DATA),
        .ADDR_W(c_WA_W)
    ) u_w_mem (
        .clk      (clk),
        .i_wr_en  (w_w_we),
        .i_wr_addr(r_li),
        .i_wr_data(s_data),
        .i_rd_addr(w_w_raddr),
        .o_rd_data(w_w_rdata)
    );

    feeder_regfile #(
        .DEPTH (N),
        .WIDTH (W_DATA),
        .ADDR_W(c_K_W)
    ) u_x_mem (
        .clk      (clk),
        .i_wr_en  (w_x_we),
        .i_wr_addr(c_K_W'(r_li)),
        .i_wr_data(s_data),
        .i_rd_addr(r_col),
        .o_rd_data(w_x_rdata)
    );

    // Next-state, counter and output-pair decode; outputs idle at zero outside COMPUTE.
    always_comb begin
        w_state_nxt = r_state;
        w_li_nxt    = r_li;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_a_nxt     = '0;
        w_b_nxt     = '0;
        w_valid_nxt = 1'b0;
        w_first_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        case (r_state)
            LOAD_W: begin
                if (w_xfer) begin
                    if (r_li == c_LI_W_LAST) begin
                        w_li_nxt    = '0;
                        w_state_nxt = LOAD_X;
                    end else begin
                        w_li_nxt = r_li + c_WA_W'(1);
                    end
                end
            end
            LOAD_X: begin
                if (w_xfer) begin
                    if (r_li == c_LI_X_LAST) begin
                        w_li_nxt    = '0;
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
                        w_state_nxt = COMPUTE;
                    end else begin
                        w_li_nxt = r_li + c_WA_W'(1);
                    end
                end
            end
            COMPUTE: begin
                w_a_nxt     = w_w_rdata;
                w_b_nxt     = w_x_rdata;
                w_valid_nxt = 1'b1;
                w_first_nxt = (r_col == '0);
                w_last_nxt  = (r_col == c_COL_LAST);
                if (r_col == c_COL_LAST) begin
                    w_col_nxt = '0;
                    if (r_row == c_ROW_LAST) begin
                        w_row_nxt   = '0;
                        w_state_nxt = LOAD_W;
                    end else begin
                        w_row_nxt = r_row + c_R_W'(1);
                    end
                end else begin
                    w_col_nxt = r_col + c_K_W'(1);
                end
            end
            default: begin
                w_state_nxt = LOAD_W;
            end
        endcase
    end

    // State, counters and registered operand outputs; reset aborts any job.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LOAD_W;
            r_li    <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_li    <= w_li_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_valid <= w_valid_nxt;
            r_first <= w_first_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign valid_out = r_valid;
    assign first_out = r_first;
    assign last_out  = r_last;

endmodule
`default_nettype wire
